// File: rtl/au_sum_zero_bist_if.sv
// Bus between the sum-zero BIST controller and its environment:
// run control and status, plus the stimulus and response of the detector under test.
interface au_sum_zero_bist_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             z;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             busy;
    logic             done;
    logic             pass;
    logic [31:0]      num_test;
    logic [31:0]      num_fail;
    logic             fail_vld;
    logic [WIDTH-1:0] fail_a;
    logic [WIDTH-1:0] fail_b;
    logic             fail_ci;

    modport master (
        input  start, z,
        output a, b, ci, busy, done, pass, num_test, num_fail,
               fail_vld, fail_a, fail_b, fail_ci
    );

    modport slave (
        output start, z,
        input  a, b, ci, busy, done, pass, num_test, num_fail,
               fail_vld, fail_a, fail_b, fail_ci
    );
endinterface

// File: rtl/au_sum_zero_bist.sv
// Exhaustive BIST for a sum-zero detector: walks every (a, b, ci) vector, compares the
// returned z flag against an internal reference and records counts and the first failure.
module au_sum_zero_bist #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    au_sum_zero_bist_if.master    bus
);
    localparam int         IDX_W    = 2 * WIDTH + 1;
    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   idx;
    logic [3:0]         hold;
    logic [31:0]        num_test;
    logic [31:0]        num_fail;
    logic               pass;
    logic               fail_vld;
    logic [WIDTH-1:0]   fail_a;
    logic [WIDTH-1:0]   fail_b;
    logic               fail_ci;
    logic [WIDTH:0]     ref_sum;
    logic               z_ref;
    logic               mismatch;
    logic               accept;
    logic               sample;
    logic               last;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // The index is the vector itself: ci in the LSB, then b, then a, so counting walks the required order.
    assign bus.a  = idx[IDX_W-1 -: WIDTH];
    assign bus.b  = idx[WIDTH:1];
    assign bus.ci = idx[0];

    // Sum is zero modulo 2^WIDTH exactly when the full sum is 0 or 2^WIDTH.
    assign ref_sum  = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.ci};
    assign z_ref    = (ref_sum == '0) || (ref_sum == {1'b1, {WIDTH{1'b0}}});
    assign mismatch = (bus.z !== z_ref);

    assign accept = bus.start && (state != RUN);
    assign sample = (state == RUN) && (hold == SETTLE_C);
    assign last   = (idx == {IDX_W{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (bus.start)     state_next = RUN;
            RUN:        if (sample && last) state_next = DONE;
            default:                        state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            hold     <= '0;
            num_test <= '0;
            num_fail <= '0;
            pass     <= 1'b0;
            fail_vld <= 1'b0;
            fail_a   <= '0;
            fail_b   <= '0;
            fail_ci  <= 1'b0;
        end else if (accept) begin
            idx      <= '0;
            hold     <= '0;
            num_test <= '0;
            num_fail <= '0;
            pass     <= 1'b0;
            fail_vld <= 1'b0;
            fail_a   <= '0;
            fail_b   <= '0;
            fail_ci  <= 1'b0;
        end else if (sample) begin
            num_test <= sat_inc(num_test);
            hold     <= '0;
            if (mismatch) begin
                num_fail <= sat_inc(num_fail);
                if (!fail_vld) begin
                    fail_vld <= 1'b1;
                    fail_a   <= bus.a;
                    fail_b   <= bus.b;
                    fail_ci  <= bus.ci;
                end
            end
            // On the final vector the index stays put so the last vector remains on the bus.
            if (last) pass <= (num_fail == '0) && !mismatch;
            else      idx  <= idx + 1'b1;
        end else if (state == RUN) begin
            hold <= hold + 4'd1;
        end
    end

    assign bus.busy     = (state == RUN);
    assign bus.done     = (state == DONE);
    assign bus.pass     = pass;
    assign bus.num_test = num_test;
    assign bus.num_fail = num_fail;
    assign bus.fail_vld = fail_vld;
    assign bus.fail_a   = fail_a;
    assign bus.fail_b   = fail_b;
    assign bus.fail_ci  = fail_ci;
endmodule
